// File: rtl/bank_cmd_arbiter.sv
// Bank command arbiter: per-bank open-row FSMs with tRCD/tRP/tRAS/tRRD timing
// and a round-robin grant of at most one ACT/RD/WR/PRE command per cycle.
module bank_cmd_arbiter #(
  parameter  int NUM_BANKS = 8,
  parameter  int ROW_W     = 16,
  parameter  int T_RCD     = 4,
  parameter  int T_RP      = 4,
  parameter  int T_RAS     = 10,
  parameter  int T_RRD     = 2,
  parameter  int CNT_W     = 5,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_BANKS-1:0]       req_valid,
  input  logic [NUM_BANKS-1:0]       req_is_write,
  input  logic [NUM_BANKS*ROW_W-1:0] req_row,
  output logic [NUM_BANKS-1:0]       req_ready,
  input  logic                       sched_hold,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [2:0]                 cmd_type,
  output logic [BANK_W-1:0]          cmd_bank,
  output logic [ROW_W-1:0]           cmd_row,
  output logic [NUM_BANKS-1:0]       bank_open
);
  localparam logic [2:0] CMD_NONE = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'd0,
    ST_OPENING = 2'd1,
    ST_OPEN    = 2'd2,
    ST_CLOSING = 2'd3
  } bank_state_e;

  bank_state_e          state_r     [NUM_BANKS];
  bank_state_e          state_s     [NUM_BANKS];
  logic [ROW_W-1:0]     open_row_r  [NUM_BANKS];
  logic [CNT_W-1:0]     rcd_cnt_r   [NUM_BANKS];
  logic [CNT_W-1:0]     rp_cnt_r    [NUM_BANKS];
  logic [CNT_W-1:0]     ras_cnt_r   [NUM_BANKS];
  logic [ROW_W-1:0]     row_s       [NUM_BANKS];
  logic [2:0]           cand_type_s [NUM_BANKS];
  logic [CNT_W-1:0]     rrd_cnt_r;
  logic [BANK_W-1:0]    rr_ptr_r;
  logic                 rst_d_r;
  logic [NUM_BANKS-1:0] elig_s;
  logic [NUM_BANKS-1:0] act_fire_s;
  logic [NUM_BANKS-1:0] pre_fire_s;
  logic                 found_s;
  logic [BANK_W-1:0]    gnt_s;
  logic                 fire_s;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] cnt);
    if (cnt == {CNT_W{1'b0}}) begin
      sat_dec = {CNT_W{1'b0}};
    end else begin
      sat_dec = cnt - CNT_W'(1);
    end
  endfunction

  // Per-bank candidate command from bank state, timing and the pending request
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      row_s[i]       = req_row[i*ROW_W +: ROW_W];
      elig_s[i]      = 1'b0;
      cand_type_s[i] = CMD_NONE;
      if (req_valid[i]) begin
        case (state_r[i])
          ST_CLOSED: begin
            if (rrd_cnt_r == {CNT_W{1'b0}}) begin
              elig_s[i]      = 1'b1;
              cand_type_s[i] = CMD_ACT;
            end else begin
              elig_s[i]      = 1'b0;
            end
          end
          ST_OPEN: begin
            if (open_row_r[i] == row_s[i]) begin
              elig_s[i]      = 1'b1;
              cand_type_s[i] = req_is_write[i] ? CMD_WR : CMD_RD;
            end else if (ras_cnt_r[i] == {CNT_W{1'b0}}) begin
              elig_s[i]      = 1'b1;
              cand_type_s[i] = CMD_PRE;
            end else begin
              elig_s[i]      = 1'b0;
            end
          end
          default: elig_s[i] = 1'b0;
        endcase
      end else begin
        elig_s[i] = 1'b0;
      end
    end
  end

  // Round-robin search; the pointer add wraps naturally since NUM_BANKS is 2^n
  always_comb begin
    found_s = 1'b0;
    gnt_s   = {BANK_W{1'b0}};
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (!found_s && elig_s[rr_ptr_r + BANK_W'(k)]) begin
        found_s = 1'b1;
        gnt_s   = rr_ptr_r + BANK_W'(k);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Command presentation, handshake and per-bank fire decode
  always_comb begin
    cmd_valid = found_s & ~sched_hold & ~rst & ~rst_d_r;
    fire_s    = cmd_valid & cmd_ready;
    if (cmd_valid) begin
      cmd_type = cand_type_s[gnt_s];
      cmd_bank = gnt_s;
      cmd_row  = (cand_type_s[gnt_s] == CMD_ACT) ? row_s[gnt_s] : open_row_r[gnt_s];
    end else begin
      cmd_type = CMD_NONE;
      cmd_bank = {BANK_W{1'b0}};
      cmd_row  = {ROW_W{1'b0}};
    end
    for (int i = 0; i < NUM_BANKS; i++) begin
      req_ready[i]  = fire_s && (cmd_bank == BANK_W'(i)) &&
                      ((cmd_type == CMD_RD) || (cmd_type == CMD_WR));
      act_fire_s[i] = fire_s && (cmd_bank == BANK_W'(i)) && (cmd_type == CMD_ACT);
      pre_fire_s[i] = fire_s && (cmd_bank == BANK_W'(i)) && (cmd_type == CMD_PRE);
      bank_open[i]  = ~rst && ((state_r[i] == ST_OPEN) || (state_r[i] == ST_OPENING));
    end
  end

  // Per-bank FSM next state; counters of 1 expire on this edge
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      state_s[i] = state_r[i];
      case (state_r[i])
        ST_CLOSED: begin
          if (act_fire_s[i]) state_s[i] = (T_RCD <= 1) ? ST_OPEN : ST_OPENING;
          else               state_s[i] = ST_CLOSED;
        end
        ST_OPENING: begin
          if (rcd_cnt_r[i] <= CNT_W'(1)) state_s[i] = ST_OPEN;
          else                           state_s[i] = ST_OPENING;
        end
        ST_OPEN: begin
          if (pre_fire_s[i]) state_s[i] = (T_RP <= 1) ? ST_CLOSED : ST_CLOSING;
          else               state_s[i] = ST_OPEN;
        end
        ST_CLOSING: begin
          if (rp_cnt_r[i] <= CNT_W'(1)) state_s[i] = ST_CLOSED;
          else                          state_s[i] = ST_CLOSING;
        end
        default: state_s[i] = ST_CLOSED;
      endcase
    end
  end

  // State, timing counters and grant pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_d_r   <= 1'b1;
      rrd_cnt_r <= {CNT_W{1'b0}};
      rr_ptr_r  <= {BANK_W{1'b0}};
      for (int i = 0; i < NUM_BANKS; i++) begin
        state_r[i]    <= ST_CLOSED;
        open_row_r[i] <= {ROW_W{1'b0}};
        rcd_cnt_r[i]  <= {CNT_W{1'b0}};
        rp_cnt_r[i]   <= {CNT_W{1'b0}};
        ras_cnt_r[i]  <= {CNT_W{1'b0}};
      end
    end else begin
      rst_d_r   <= 1'b0;
      rrd_cnt_r <= (|act_fire_s) ? CNT_W'(T_RRD - 1) : sat_dec(rrd_cnt_r);
      rr_ptr_r  <= fire_s ? (gnt_s + BANK_W'(1)) : rr_ptr_r;
      for (int i = 0; i < NUM_BANKS; i++) begin
        state_r[i] <= state_s[i];
        if (act_fire_s[i]) begin
          open_row_r[i] <= row_s[i];
          rcd_cnt_r[i]  <= CNT_W'(T_RCD - 1);
          ras_cnt_r[i]  <= CNT_W'(T_RAS - 1);
        end else begin
          open_row_r[i] <= open_row_r[i];
          rcd_cnt_r[i]  <= sat_dec(rcd_cnt_r[i]);
          ras_cnt_r[i]  <= sat_dec(ras_cnt_r[i]);
        end
        rp_cnt_r[i] <= pre_fire_s[i] ? CNT_W'(T_RP - 1) : sat_dec(rp_cnt_r[i]);
      end
    end
  end

endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Self-checking bench for bank_cmd_arbiter: directed scenarios plus a randomized
// run scored against a time-stamp based model of the bank timing rules.
module tb_bank_cmd_arbiter;
  localparam int NB = 8;
  localparam int RW = 16;
  localparam int T_RCD = 4, T_RP = 4, T_RAS = 10, T_RRD = 2;
  localparam logic [2:0] C_NONE = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3, C_PRE = 3'd4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NB-1:0]  req_valid, req_is_write, req_ready, bank_open;
  logic [NB*RW-1:0] req_row;
  logic           sched_hold, cmd_valid, cmd_ready;
  logic [2:0]     cmd_type;
  logic [2:0]     cmd_bank;
  logic [RW-1:0]  cmd_row;

  int vectors = 0;
  int miscompares = 0;

  bank_cmd_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_is_write(req_is_write),
    .req_row(req_row), .req_ready(req_ready), .sched_hold(sched_hold),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_bank(cmd_bank), .cmd_row(cmd_row), .bank_open(bank_open)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int b, input logic [RW-1:0] row, input logic wr);
    req_valid[b]         = 1'b1;
    req_row[b*RW +: RW]  = row;
    req_is_write[b]      = wr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; sched_hold = 1'b0; cmd_ready = 1'b1;
    req_valid = '1; req_is_write = '0;
    for (int b = 0; b < NB; b++) req_row[b*RW +: RW] = 16'(16'h1000 + b);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) rst = 1'b0;
      if (c == 2) cmd_ready = 1'b0;
      @(negedge clk);
      vectors++;
      if (c < 2 && {cmd_valid, cmd_type, req_ready, bank_open} !== 20'h0) begin
        miscompares++;
        $display("FAIL reset c%0d: got v=%0b t=%0d rdy=%b open=%b, expected all zero",
                 c, cmd_valid, cmd_type, req_ready, bank_open);
      end
      if (c == 2 && {cmd_valid, cmd_type, cmd_bank, cmd_row} !== {1'b1, C_ACT, 3'd0, 16'h1000}) begin
        miscompares++;
        $display("FAIL reset_first_act: got v=%0b t=%0d b=%0d row=%h, expected v=1 t=1 b=0 row=1000",
                 cmd_valid, cmd_type, cmd_bank, cmd_row);
      end
      next_cycle();
    end
    req_valid = '0; cmd_ready = 1'b1;
  endtask

  task automatic test_single_read();
    logic [2:0] et;
    set_req(2, 16'h0055, 1'b0);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      et = (c == 0) ? C_ACT : (c == 4) ? C_RD : C_NONE;
      vectors++;
      if (cmd_type !== et || (et != C_NONE && (cmd_bank !== 3'd2 || cmd_row !== 16'h0055))) begin
        miscompares++;
        $display("FAIL single_read cmd c%0d: got t=%0d b=%0d row=%h, expected t=%0d b=2 row=0055",
                 c, cmd_type, cmd_bank, cmd_row, et);
      end
      vectors++;
      if (req_ready !== ((c == 4) ? 8'h04 : 8'h00) || bank_open[2] !== (c >= 1)) begin
        miscompares++;
        $display("FAIL single_read rdy/open c%0d: got rdy=%b open2=%0b, expected rdy=%b open2=%0b",
                 c, req_ready, bank_open[2], (c == 4) ? 8'h04 : 8'h00, c >= 1);
      end
      next_cycle();
      if (c == 4) req_valid[2] = 1'b0;
    end
  endtask

  task automatic test_row_miss();
    logic [2:0] et;
    logic [RW-1:0] er;
    set_req(1, 16'h0010, 1'b0);
    for (int c = 0; c <= 19; c++) begin
      @(negedge clk);
      case (c)
        0:       begin et = C_ACT; er = 16'h0010; end
        4:       begin et = C_RD;  er = 16'h0010; end
        10:      begin et = C_PRE; er = 16'h0010; end
        14:      begin et = C_ACT; er = 16'h0020; end
        18:      begin et = C_WR;  er = 16'h0020; end
        default: begin et = C_NONE; er = 16'h0000; end
      endcase
      vectors++;
      if (cmd_type !== et || (et != C_NONE && (cmd_bank !== 3'd1 || cmd_row !== er))) begin
        miscompares++;
        $display("FAIL row_miss c%0d: got t=%0d b=%0d row=%h, expected t=%0d b=1 row=%h",
                 c, cmd_type, cmd_bank, cmd_row, et, er);
      end
      next_cycle();
      if (c == 4) set_req(1, 16'h0020, 1'b1);
      if (c == 18) req_valid[1] = 1'b0;
    end
  endtask

  task automatic test_contention();
    logic [2:0] et [10];
    int eb [10];
    et = '{C_ACT, C_NONE, C_ACT, C_NONE, C_ACT, C_RD, C_WR, C_NONE, C_RD, C_NONE};
    eb = '{0, 0, 3, 0, 7, 0, 3, 0, 7, 0};
    do_reset();
    set_req(0, 16'h0100, 1'b0);
    set_req(3, 16'h0300, 1'b1);
    set_req(7, 16'h0700, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if (cmd_type !== et[c] || (et[c] != C_NONE && cmd_bank !== 3'(eb[c]))) begin
        miscompares++;
        $display("FAIL contention c%0d: got t=%0d b=%0d, expected t=%0d b=%0d",
                 c, cmd_type, cmd_bank, et[c], eb[c]);
      end
      next_cycle();
      if (et[c] == C_RD || et[c] == C_WR) req_valid[eb[c]] = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    cmd_ready = 1'b0;
    set_req(5, 16'h0500, 1'b0);
    for (int c = 0; c <= 10; c++) begin
      if (c == 6) cmd_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (c <= 6 && ({cmd_valid, cmd_type, cmd_bank} !== {1'b1, C_ACT, 3'd5} ||
                     req_ready !== 8'h00 || bank_open[5] !== 1'b0)) begin
        miscompares++;
        $display("FAIL backpressure c%0d: got v=%0b t=%0d b=%0d rdy=%b open5=%0b, expected v=1 t=1 b=5 rdy=0 open5=0",
                 c, cmd_valid, cmd_type, cmd_bank, req_ready, bank_open[5]);
      end
      if (c > 6 && c < 10 && (cmd_valid !== 1'b0 || bank_open[5] !== 1'b1)) begin
        miscompares++;
        $display("FAIL backpressure_after c%0d: got v=%0b open5=%0b, expected v=0 open5=1",
                 c, cmd_valid, bank_open[5]);
      end
      if (c == 10 && ({cmd_type, cmd_bank} !== {C_RD, 3'd5} || req_ready !== 8'h20)) begin
        miscompares++;
        $display("FAIL backpressure_rd: got t=%0d b=%0d rdy=%b, expected t=2 b=5 rdy=00100000",
                 cmd_type, cmd_bank, req_ready);
      end
      next_cycle();
    end
    req_valid[5] = 1'b0;
  endtask

  task automatic test_hold();
    set_req(4, 16'h0444, 1'b0);
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      vectors++;
      if (c == 0 && {cmd_valid, cmd_type, cmd_bank} !== {1'b1, C_ACT, 3'd4}) begin
        miscompares++;
        $display("FAIL hold_act: got v=%0b t=%0d b=%0d, expected v=1 t=1 b=4", cmd_valid, cmd_type, cmd_bank);
      end
      if (c >= 1 && c <= 8 && {cmd_valid, cmd_type, req_ready} !== 12'h0) begin
        miscompares++;
        $display("FAIL hold c%0d: got v=%0b t=%0d rdy=%b, expected v=0 t=0 rdy=0", c, cmd_valid, cmd_type, req_ready);
      end
      if (c == 9 && ({cmd_valid, cmd_type, cmd_bank} !== {1'b1, C_RD, 3'd4} || req_ready !== 8'h10)) begin
        miscompares++;
        $display("FAIL hold_release: got v=%0b t=%0d b=%0d rdy=%b, expected v=1 t=2 b=4 rdy=00010000",
                 cmd_valid, cmd_type, cmd_bank, req_ready);
      end
      next_cycle();
      sched_hold = (c < 8);
    end
    sched_hold = 1'b0;
    req_valid[4] = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_req(6, 16'h0666, 1'b1);
    for (int c = 0; c <= 7; c++) begin
      rst = (c == 1);
      @(negedge clk);
      vectors++;
      if ((c == 0 || c == 3) && {cmd_valid, cmd_type, cmd_bank, cmd_row} !== {1'b1, C_ACT, 3'd6, 16'h0666}) begin
        miscompares++;
        $display("FAIL reset_mid_act c%0d: got v=%0b t=%0d b=%0d row=%h, expected v=1 t=1 b=6 row=0666",
                 c, cmd_valid, cmd_type, cmd_bank, cmd_row);
      end
      if ((c == 1 || c == 2) && (cmd_valid !== 1'b0 || bank_open !== 8'h00)) begin
        miscompares++;
        $display("FAIL reset_mid c%0d: got v=%0b open=%b, expected v=0 open=0", c, cmd_valid, bank_open);
      end
      if (c == 7 && {cmd_type, cmd_bank, req_ready} !== {C_WR, 3'd6, 8'h40}) begin
        miscompares++;
        $display("FAIL reset_mid_wr: got t=%0d b=%0d rdy=%b, expected t=3 b=6 rdy=01000000",
                 cmd_type, cmd_bank, req_ready);
      end
      next_cycle();
    end
    rst = 1'b0;
    req_valid[6] = 1'b0;
  endtask

  // Randomized traffic against a model built on per-bank event time stamps
  task automatic test_random();
    bit m_open [NB];
    logic [RW-1:0] m_row [NB], p_row [NB];
    int m_act_t [NB], m_pre_t [NB], p_age [NB];
    bit p_valid [NB], p_wr [NB];
    int m_act_any, m_rr, now, max_age, eb, b;
    bit m_gap, ev;
    logic [2:0] et;
    logic [RW-1:0] er;
    logic [NB-1:0] e_rdy, e_open;
    do_reset();
    m_act_any = -1000; m_rr = 0; now = 0; max_age = 0; m_gap = 1'b0;
    for (int i = 0; i < NB; i++) begin
      m_open[i] = 1'b0; m_row[i] = '0; m_act_t[i] = -1000; m_pre_t[i] = -1000;
      p_valid[i] = 1'b0; p_wr[i] = 1'b0; p_row[i] = '0; p_age[i] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst        = ($urandom_range(0, 299) == 0);
      sched_hold = ($urandom_range(0, 9) == 0);
      cmd_ready  = ($urandom_range(0, 4) != 0);
      for (int i = 0; i < NB; i++) begin
        if (!p_valid[i] && $urandom_range(0, 3) == 0) begin
          p_valid[i] = 1'b1; p_age[i] = 0; p_wr[i] = 1'($urandom_range(0, 1));
          p_row[i] = 16'(16'h0010 * $urandom_range(1, 3) + i);
        end else if (p_valid[i] && $urandom_range(0, 199) == 0) begin
          p_row[i] = 16'(16'h0040 + i);
        end
        req_valid[i] = p_valid[i]; req_is_write[i] = p_wr[i];
        req_row[i*RW +: RW] = p_row[i];
      end
      ev = 1'b0; et = C_NONE; eb = 0; er = '0;
      if (!rst && !m_gap && !sched_hold) begin
        for (int k = 0; k < NB; k++) begin
          b = (m_rr + k) % NB;
          if (!ev && p_valid[b]) begin
            if (!m_open[b]) begin
              if (now >= m_pre_t[b] + T_RP && now >= m_act_any + T_RRD) begin
                ev = 1'b1; et = C_ACT; eb = b; er = p_row[b];
              end
            end else if (now >= m_act_t[b] + T_RCD) begin
              if (m_row[b] == p_row[b]) begin
                ev = 1'b1; et = p_wr[b] ? C_WR : C_RD; eb = b; er = m_row[b];
              end else if (now >= m_act_t[b] + T_RAS) begin
                ev = 1'b1; et = C_PRE; eb = b; er = m_row[b];
              end
            end
          end
        end
      end
      e_rdy = '0;
      if (ev && cmd_ready && (et == C_RD || et == C_WR)) e_rdy[eb] = 1'b1;
      for (int i = 0; i < NB; i++) e_open[i] = !rst && m_open[i];
      @(negedge clk);
      vectors++;
      if ({cmd_valid, cmd_type, cmd_bank, cmd_row, req_ready, bank_open} !==
          {ev, et, 3'(eb), er, e_rdy, e_open}) begin
        miscompares++;
        $display("FAIL random cyc %0d: got v=%0b t=%0d b=%0d row=%h rdy=%b open=%b, expected v=%0b t=%0d b=%0d row=%h rdy=%b open=%b",
                 cyc, cmd_valid, cmd_type, cmd_bank, cmd_row, req_ready, bank_open,
                 ev, et, eb, er, e_rdy, e_open);
      end
      if (rst) begin
        m_gap = 1'b1; m_rr = 0; m_act_any = -1000;
        for (int i = 0; i < NB; i++) begin
          m_open[i] = 1'b0; m_act_t[i] = -1000; m_pre_t[i] = -1000;
        end
      end else begin
        m_gap = 1'b0;
        if (ev && cmd_ready) begin
          case (et)
            C_ACT: begin
              m_open[eb] = 1'b1; m_row[eb] = er; m_act_t[eb] = now; m_act_any = now;
            end
            C_PRE: begin m_open[eb] = 1'b0; m_pre_t[eb] = now; end
            default: p_valid[eb] = 1'b0;
          endcase
          m_rr = (eb + 1) % NB;
        end
      end
      for (int i = 0; i < NB; i++) begin
        if (p_valid[i]) p_age[i]++;
        if (p_age[i] > max_age) max_age = p_age[i];
      end
      now++;
      next_cycle();
    end
    rst = 1'b0; sched_hold = 1'b0; cmd_ready = 1'b1; req_valid = '0;
    vectors++;
    if (max_age > 400) begin
      miscompares++;
      $display("FAIL random_liveness: got max wait %0d cycles, expected at most 400", max_age);
    end
  endtask

  initial begin
    rst = 1'b1; sched_hold = 1'b0; cmd_ready = 1'b1;
    req_valid = '0; req_is_write = '0; req_row = '0;
    #1;
    test_reset();
    test_single_read();
    test_row_miss();
    test_contention();
    test_backpressure();
    test_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bank_cmd_arbiter.md
Name: bank_cmd_arbiter

Overview:
Sits between the per-bank request queues and the command scheduler's issue FIFO. It shares the single issue path among NUM_BANKS requesters and decides per bank whether the next command is ACTIVE, READ/WRITE or PRECHARGE. It tracks open-row state and per-bank tRCD/tRP/tRAS plus global tRRD, so only timing-legal, row-correct commands enter the issue FIFO. Round-robin grant, at most one command per cycle.

Parameters:
NUM_BANKS, 8, number of bank requesters (power of 2)
ROW_W, 16, row address width
T_RCD, 4, cycles from ACT to the first RD/WR on the same bank
T_RP, 4, cycles from PRE to the next ACT on the same bank
T_RAS, 10, cycles from ACT to the earliest PRE on the same bank
T_RRD, 2, cycles from ACT to the next ACT on any bank
CNT_W, 5, timing counter width (must hold the maximum of the T_* values)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_BANKS  bank i has a pending column request
req_is_write  in  NUM_BANKS  1 = WRITE, 0 = READ
req_row  in  NUM_BANKS*ROW_W  target row of bank i, in slice [i*ROW_W +: ROW_W]
req_ready  out  NUM_BANKS  one-cycle pulse: bank i's RD/WR was accepted by the FIFO
sched_hold  in  1  blocks all issue, for example during refresh
cmd_valid  out  1  command presented to the issue FIFO
cmd_ready  in  1  issue FIFO not full
cmd_type  out  3  1 = ACT, 2 = RD, 3 = WR, 4 = PRE, 0 = none
cmd_bank  out  log2(NUM_BANKS)  target bank
cmd_row  out  ROW_W  row for ACT; the open row for RD/WR/PRE
bank_open  out  NUM_BANKS  bank i is in state OPEN or OPENING

Behaviour:
- Per-bank FSM:
  - CLOSED: ACT fire -> OPENING.
  - OPENING: tRCD counter expires -> OPEN.
  - OPEN: PRE fire -> CLOSING.
  - CLOSING: tRP counter expires -> CLOSED.
- Per-bank registers: open_row, rcd_cnt, rp_cnt, ras_cnt. Global register: rrd_cnt.
- Counter rules:
  - Counters load on fire, decrement to 0 each cycle and saturate at 0.
  - ACT fire at cycle t: rcd_cnt=T_RCD-1, ras_cnt=T_RAS-1, rrd_cnt=T_RRD-1.
  - Resulting windows after ACT at t: RD/WR on that bank legal from t+T_RCD; PRE legal from t+T_RAS; ACT on any bank legal from t+T_RRD.
  - PRE fire at cycle t: rp_cnt=T_RP-1; next ACT on that bank legal from t+T_RP.
- Eligibility (combinational) for bank i with req_valid[i]=1:
  - CLOSED and rrd_cnt==0 and no ACT fired this cycle -> candidate ACT with row req_row[i].
  - OPEN and open_row==req_row[i] -> candidate RD or WR, per req_is_write[i].
  - OPEN and row mismatch and ras_cnt==0 -> candidate PRE.
  - OPENING or CLOSING -> not eligible.
- Grant: round-robin over eligible banks, starting at rr_ptr. On fire, rr_ptr becomes granted bank+1, wrapping NUM_BANKS-1 -> 0. rr_ptr does not move without a fire.
- Output:
  - cmd_valid = (any eligible) & ~sched_hold & ~rst.
  - cmd_* are combinational from registered state; cmd_type=0 and cmd_bank/cmd_row=0 when not valid.
- Fire = cmd_valid & cmd_ready. All state updates happen at the fire clock edge. Without a fire, the selection may change cycle to cycle; it is not held stable.
- req_ready[i] = fire & (cmd_type is RD or WR) & (cmd_bank==i). It is never asserted for ACT or PRE.
- Request protocol: the requester holds req_valid, req_row and req_is_write stable until req_ready. A row change while waiting is a protocol error; the block closes and reopens as needed without hanging.
- Row-hit policy: the bank stays OPEN after RD/WR (open-page). No auto-precharge.
- sched_hold=1: no fire. Counters still decrement.
- Reset values, while rst=1 and on the following cycle:
  - All banks CLOSED; all counters 0; rr_ptr=0; open_row=0.
  - cmd_valid=0, cmd_type=0, req_ready=0, bank_open=0.
- Reset mid-operation discards all open-row knowledge. The higher level must reissue a precharge-all after reset.
- Latency: request on a CLOSED bank with an idle arbiter gives ACT in the same cycle (combinational), then RD/WR T_RCD cycles later.

Test Plan:
- Single read, bank 2, row 0x0055, cmd_ready=1 from t0 -> ACT bank2 row 0x0055 at t0; RD at t0+4; req_ready[2] pulses at t0+4 only; bank_open[2]=1 from t0+1.
- Row miss: bank 1 open on row 0x10 (ACT at t0), request row 0x20 -> PRE no earlier than t0+10; ACT row 0x20 at PRE+4; WR at ACT+4.
- Contention: banks 0, 3 and 7 all CLOSED, all requesting at t0 -> ACTs in order 0, 3, 7 at t0, t0+2, t0+4 (tRRD); then column commands round-robin, with no bank granted twice while another eligible bank waits.
- Backpressure: cmd_ready=0 for 6 cycles with bank 5 eligible -> cmd_valid=1, no state change, req_ready=0; on the first cycle with cmd_ready=1, exactly one fire occurs.
- sched_hold=1 for 8 cycles after an ACT on bank 4 -> cmd_valid=0 throughout; RD issues on the first cycle after hold drops (tRCD already elapsed).
- rst=1 for one cycle while bank 6 is OPENING -> the next cycle has bank_open=0 and cmd_valid=0; the same request then re-ACTs bank 6.
